seq_divider_unit: RTL and testbench
===================================

// Module: seq_divider_unit
// PURPOSE
//  Unsigned multi-cycle restoring divider; the responder side of the start/done division
//  handshake issued by the PID gain tuner when it computes Kp/Ki/Kd.
//  Accepts a dividend/divisor pair and retires one quotient bit per clock.
//  Holds the result until the initiator withdraws its request.
// PARAMETERS
//  DATA_WIDTH  32  operand, quotient and remainder width (unsigned), >=2
// PORTS
//  clk              in   1           division clock; all state on posedge
//  reset            in   1           synchronous, active-high; returns to IDLE
//  start_division   in   1           level request from initiator
//  dividend         in   DATA_WIDTH  numerator, sampled only on IDLE->RUN
//  divisor          in   DATA_WIDTH  denominator, sampled only on IDLE->RUN
//  quotient         out  DATA_WIDTH  registered result, valid while division_done=1
//  remainder        out  DATA_WIDTH  registered result, valid while division_done=1
//  division_active  out  1           high in RUN
//  division_done    out  1           high in DONE
//  div_by_zero      out  1           only with SEQ_DIV_ZERO_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; quotient=0, remainder=0, division_active=0, division_done=0
//   (div_by_zero=0); internal partial remainder and iteration counter = 0.
//  Reset mid-RUN/DONE: the operation is abandoned on the same edge; no done pulse.
//  FSM: IDLE -> RUN | DONE; RUN -> DONE; DONE -> IDLE.
//  IDLE: if start_division=1 at an edge, latch dividend/divisor.
//   divisor!=0: go to RUN and set counter=DATA_WIDTH.
//   divisor==0: go straight to DONE with quotient=all ones and remainder=dividend.
//  RUN: each edge shifts the next dividend MSB into the (DATA_WIDTH+1)-bit partial
//   remainder, then compares it with the divisor. If partial >= divisor, subtract and
//   shift 1 into the quotient; else shift 0. Decrement the counter. When the counter
//   reaches 0, load the outputs and go to DONE.
//  Latency: division_done rises exactly DATA_WIDTH+1 edges after the edge that sampled
//   start=1 in IDLE (33 for the default); divide-by-zero takes 1 edge.
//  Input changes during RUN are ignored. start_division may drop during RUN; the
//   operation still completes.
//  DONE: quotient/remainder/done are held stable while start_division=1. The first edge
//   with start_division=0 clears division_done and enters IDLE. Outputs keep their last
//   values and become don't-care once done=0. DONE always lasts >=1 cycle.
//  A new operation needs start low for >=1 edge after DONE (level retrigger in IDLE).
//   There is no back-to-back restart from DONE.
//  Results satisfy dividend == quotient*divisor + remainder and remainder < divisor
//   (divisor!=0). There is no overflow case for unsigned operands.
// CONFIGURATION
//  SEQ_DIV_ZERO_FLAG_EN defined: adds output div_by_zero. It is set together with
//   division_done when the latched divisor==0, cleared when leaving DONE, and 0 otherwise.
//  Undefined: the port is absent. The divide-by-zero result (all-ones quotient,
//   remainder=dividend, 1-edge latency) is identical in both builds.
// TESTING
//  900/100 (45*Kp_max, Kp_max=20), start held -> done on edge 33; q=9, r=0; active high edges 1..32.
//  0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0. 7/9 -> q=0, r=7. 0/5 -> q=0, r=0. All at 33-edge latency.
//  100/0 -> done after 1 edge; q=0xFFFFFFFF, r=100; div_by_zero=1 only in the flag build.
//  Hold start 5 cycles past done -> outputs and done stable; drop start -> done=0 next edge,
//   then restart 84/70 -> q=1, r=14.
//  Change dividend/divisor mid-RUN, drop start mid-RUN -> original result still delivered.
//  Assert reset at edge 10 of RUN -> all outputs 0, IDLE; a following 1000/3 gives q=333, r=1.
//  Random 2000 operand pairs vs reference model; check latency and q*d+r identity.

Source files
------------

// File: rtl/seq_divider_unit.sv
// seq_divider_unit: unsigned restoring divider, one quotient bit per clock.
// Level start/done handshake: the result is held in DONE until start_division drops.
// Optional build macro SEQ_DIV_ZERO_FLAG_EN adds the div_by_zero output.

module seq_divider_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_division,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  division_active,
  output logic                  division_done
`ifdef SEQ_DIV_ZERO_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] part_q, part_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;

  // One restoring step: the (DATA_WIDTH+1)-bit shifted partial vs. the divisor.
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  ge;
  logic [DATA_WIDTH-1:0] part_next;
  logic [DATA_WIDTH-1:0] dvd_next;

  // Datapath for a single iteration.
  always_comb begin
    shifted   = {part_q, dvd_q[DATA_WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    ge        = (shifted >= {1'b0, dvs_q});
    part_next = ge ? DATA_WIDTH'(trial) : DATA_WIDTH'(shifted);
    dvd_next  = {dvd_q[DATA_WIDTH-2:0], ge};
  end

  // Next-state and result-load logic.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    unique case (state_q)
      StIdle: begin
        if (start_division) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          part_d = '0;
          if (divisor == '0) begin
            // No iterations needed: fixed all-ones quotient, dividend as remainder.
            quotient_d  = '1;
            remainder_d = dividend;
            cnt_d       = '0;
            state_d     = StDone;
          end else begin
            cnt_d   = CntW'(DATA_WIDTH);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        dvd_d  = dvd_next;
        part_d = part_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quotient_d  = dvd_next;
          remainder_d = part_next;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (!start_division) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient        = quotient_q;
  assign remainder       = remainder_q;
  assign division_active = (state_q == StRun);
  assign division_done   = (state_q == StDone);

`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic dbz_q;

  // Flag tracks DONE entered through the zero-divisor path.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbz_q <= 1'b0;
    end else if (state_q == StIdle && start_division && divisor == '0) begin
      dbz_q <= 1'b1;
    end else if (state_q == StDone && !start_division) begin
      dbz_q <= 1'b0;
    end
  end

  assign div_by_zero = dbz_q;
`else
  // No flag output; the zero-divisor result path above is identical in this build.
`endif

endmodule

// File: tb/tb_seq_divider_unit.sv
// Directed and random checks for seq_divider_unit (DATA_WIDTH = 32).

module tb_seq_divider_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_division;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        division_active;
  logic        division_done;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic        div_by_zero;
`endif

  int total = 0;
  int bad   = 0;

  seq_divider_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_division (start_division),
    .dividend       (dividend),
    .divisor        (divisor),
    .quotient       (quotient),
    .remainder      (remainder),
    .division_active(division_active),
    .division_done  (division_done)
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    .div_by_zero    (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  // Drive an operation and count edges (sampling edge = 1) until done; lat=0 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend       = a;
    divisor        = b;
    start_division = 1'b1;
    lat            = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (division_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    start_division = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    start_division = 1'b0;
    dividend       = 32'd0;
    divisor        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({quotient, remainder, division_active, division_done} !== 66'd0) begin
      bad++;
      $display("FAIL reset_outputs: got q=%0h r=%0h act=%0b done=%0b want all 0",
               quotient, remainder, division_active, division_done);
    end
`ifdef SEQ_DIV_ZERO_FLAG_EN
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_dbz: got %0b want 0", div_by_zero);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  // 900/100 stepped edge by edge, hold in DONE, release, then 84/70.
  task automatic test_basic_hold();
    int lat;
    @(negedge clk);
    dividend       = 32'd900;
    divisor        = 32'd100;
    start_division = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (i <= 32) begin
        if (division_active !== 1'b1 || division_done !== 1'b0) begin
          bad++;
          $display("FAIL basic_active edge %0d: got act=%0b done=%0b want act=1 done=0",
                   i, division_active, division_done);
        end
      end else begin
        if (division_active !== 1'b0 || division_done !== 1'b1) begin
          bad++;
          $display("FAIL basic_done edge %0d: got act=%0b done=%0b want act=0 done=1",
                   i, division_active, division_done);
        end
      end
    end
    total++;
    if (quotient !== 32'd9 || remainder !== 32'd0) begin
      bad++;
      $display("FAIL basic_result: got q=%0d r=%0d want q=9 r=0", quotient, remainder);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (division_done !== 1'b1 || quotient !== 32'd9 || remainder !== 32'd0) begin
        bad++;
        $display("FAIL hold_stable %0d: got done=%0b q=%0d r=%0d want done=1 q=9 r=0",
                 i, division_done, quotient, remainder);
      end
    end
    release_op();
    total++;
    if (division_done !== 1'b0 || division_active !== 1'b0) begin
      bad++;
      $display("FAIL release_done: got done=%0b act=%0b want 0 0",
               division_done, division_active);
    end
    run_op(32'd84, 32'd70, lat);
    total++;
    if (lat != 33 || quotient !== 32'd1 || remainder !== 32'd14) begin
      bad++;
      $display("FAIL restart_84_70: got lat=%0d q=%0d r=%0d want lat=33 q=1 r=14",
               lat, quotient, remainder);
    end
    release_op();
  endtask

  task automatic test_vectors();
    logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'd7, 32'd0, 32'd1000};
    logic [31:0] vb [4] = '{32'd1,         32'd9, 32'd5, 32'd3};
    logic [31:0] vq [4] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd333};
    logic [31:0] vr [4] = '{32'd0,         32'd7, 32'd0, 32'd1};
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], lat);
      total++;
      if (lat != 33 || quotient !== vq[k] || remainder !== vr[k]) begin
        bad++;
        $display("FAIL vector %0d (%0h/%0h): got lat=%0d q=%0h r=%0h want lat=33 q=%0h r=%0h",
                 k, va[k], vb[k], lat, quotient, remainder, vq[k], vr[k]);
      end
      release_op();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(32'd100, 32'd0, lat);
    total++;
    if (lat != 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd100) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d q=%0h r=%0d want lat=1 q=ffffffff r=100",
               lat, quotient, remainder);
    end
`ifdef SEQ_DIV_ZERO_FLAG_EN
    total++;
    if (div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_set: got %0b want 1", div_by_zero);
    end
`endif
    release_op();
`ifdef SEQ_DIV_ZERO_FLAG_EN
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dbz_clear: got %0b want 0", div_by_zero);
    end
    run_op(32'd10, 32'd3, lat);
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dbz_nonzero: got %0b want 0", div_by_zero);
    end
    release_op();
`endif
  endtask

  // Operands change and start drops mid-RUN; the latched operation must still finish.
  task automatic test_mid_run_change();
    int lat;
    @(negedge clk);
    dividend       = 32'd1234567;
    divisor        = 32'd89;
    start_division = 1'b1;
    lat            = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (division_done) begin
        lat = i;
        break;
      end
      if (i == 5) begin
        dividend       = 32'd1;
        divisor        = 32'd1;
        start_division = 1'b0;
      end
    end
    total++;
    if (lat != 33 || quotient !== 32'd13871 || remainder !== 32'd48) begin
      bad++;
      $display("FAIL mid_run_change: got lat=%0d q=%0d r=%0d want lat=33 q=13871 r=48",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (division_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_leave_done: got done=%0b want 0", division_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    dividend       = 32'd5000;
    divisor        = 32'd7;
    start_division = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset          = 1'b1;
    start_division = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({quotient, remainder, division_active, division_done} !== 66'd0) begin
      bad++;
      $display("FAIL reset_mid_run: got q=%0h r=%0h act=%0b done=%0b want all 0",
               quotient, remainder, division_active, division_done);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd1000, 32'd3, lat);
    total++;
    if (lat != 33 || quotient !== 32'd333 || remainder !== 32'd1) begin
      bad++;
      $display("FAIL after_reset_1000_3: got lat=%0d q=%0d r=%0d want lat=33 q=333 r=1",
               lat, quotient, remainder);
    end
    release_op();
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    int lat, elat;
    for (int n = 0; n < 2000; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (n % 97 == 0) b = 32'd0;
      if (b == 32'd0) begin
        eq   = 32'hFFFF_FFFF;
        er   = a;
        elat = 1;
      end else begin
        eq   = a / b;
        er   = a % b;
        elat = 33;
      end
      run_op(a, b, lat);
      total++;
      if (lat != elat || quotient !== eq || remainder !== er) begin
        bad++;
        $display("FAIL random %0d (%0h/%0h): got lat=%0d q=%0h r=%0h want lat=%0d q=%0h r=%0h",
                 n, a, b, lat, quotient, remainder, elat, eq, er);
      end
      if (b != 32'd0) begin
        total++;
        if (64'(quotient) * 64'(b) + 64'(remainder) != 64'(a) || remainder >= b) begin
          bad++;
          $display("FAIL identity %0d (%0h/%0h): got q=%0h r=%0h", n, a, b, quotient, remainder);
        end
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    test_vectors();
    test_div_zero();
    test_mid_run_change();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
